// File: rtl/range_max_finder.sv
// range_max_finder
//   Sequenced max-search engine. On an accepted start it walks a
//   synchronous-read memory from first_addr to last_addr inclusive and
//   reports the largest unsigned word and the lowest address holding it.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   start       search request, sampled only while idle
//   first_addr  first address of the window (latched on accepted start)
//   last_addr   last address of the window, inclusive (latched on start)
//   mem_rd      memory read strobe, high only while issuing a read
//   mem_addr    memory read address (always shows the current address)
//   mem_din     memory read data, valid the cycle after mem_rd
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse, results valid
//   err         window invalid (first_addr > last_addr), valid with done
//   max_val     largest word found
//   max_addr    address of the largest word
module range_max_finder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [DATA_W-1:0] max_val_reg;
  logic [ADDR_W-1:0] max_addr_reg;
  logic              err_reg;
  logic              first_reg;

  // The first word of a window always wins, so a window of all zeros still
  // reports its first address; afterwards only a strictly larger word
  // replaces the current maximum, which keeps the lowest address on ties.
  logic take_word;
  assign take_word = first_reg || (mem_din > max_val_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      last_reg     <= '0;
      max_val_reg  <= '0;
      max_addr_reg <= '0;
      err_reg      <= 1'b0;
      first_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg     <= first_addr;
            last_reg     <= last_addr;
            max_val_reg  <= '0;
            max_addr_reg <= first_addr;
            first_reg    <= 1'b1;
            if (first_addr <= last_addr) begin
              err_reg   <= 1'b0;
              state_reg <= ST_ISSUE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (take_word) begin
            max_val_reg  <= mem_din;
            max_addr_reg <= addr_reg;
          end
          first_reg <= 1'b0;
          // Test for the end before incrementing so a window ending at the
          // top address never wraps the address counter.
          if (addr_reg == last_reg) begin
            state_reg <= ST_DONE;
          end else begin
            addr_reg  <= addr_reg + 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd   = (state_reg == ST_ISSUE);
  assign mem_addr = addr_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign err      = err_reg;
  assign max_val  = max_val_reg;
  assign max_addr = max_addr_reg;

endmodule

// File: tb/tb_range_max_finder.sv
module tb_range_max_finder;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic       mem_rd;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] max_val;
  logic [3:0] max_addr;

  range_max_finder #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .max_val    (max_val),
    .max_addr   (max_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the read strobe.
  logic [7:0] mem [16];
  logic [7:0] mem_q;
  always @(posedge clk) begin
    if (mem_rd) mem_q <= mem[mem_addr];
  end
  assign mem_din = mem_q;

  int compared   = 0;
  int mismatched = 0;

  // Per-search observations
  int done_cyc;
  int done_seen;
  int busy_c1;
  int busy_after;
  int rd_addr_q[$];
  int rd_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch a search (start sampled at edge 0) and watch 40 cycles, sampling
  // on falling edges. inject_cyc > 0 pulses start with window 8..11 then.
  task automatic run_search(input logic [3:0] f, input logic [3:0] l, input int inject_cyc);
    @(negedge clk);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = 0;
    done_seen = 0;
    busy_c1 = 0;
    busy_after = -1;
    rd_addr_q.delete();
    rd_cyc_q.delete();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) busy_c1 = int'(busy);
      if (done_cyc != 0 && cyc == done_cyc + 1) busy_after = int'(busy);
      if (mem_rd) begin
        rd_addr_q.push_back(int'(mem_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_seen++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == inject_cyc) begin
        start      = 1'b1;
        first_addr = 4'd8;
        last_addr  = 4'd11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    $display("search first=%0d last=%0d done_cyc=%0d dones=%0d reads=%0d max_val=%0d max_addr=%0d err=%0b",
             f, l, done_cyc, done_seen, rd_addr_q.size(), max_val, max_addr, err);
  endtask

  int reset_dones;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'd1;
    mem[0] = 8'd3;   mem[1] = 8'd9;   mem[2] = 8'd2;   mem[3] = 8'd7;
    mem[4] = 8'd5;   mem[5] = 8'd8;   mem[6] = 8'd8;   mem[7] = 8'd1;
    mem[8] = 8'd200; mem[9] = 8'd50;  mem[10] = 8'd201; mem[11] = 8'd201;
    mem[15] = 8'd0;
    mem_q = 8'd0;

    reset_n    = 1'b0;
    start      = 1'b0;
    first_addr = 4'd0;
    last_addr  = 4'd0;
    #22;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_mem_rd",   32'(mem_rd),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_max_val",  32'(max_val),  32'd0);
    check("rst_max_addr", 32'(max_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic window 0..3 of {3,9,2,7}
    run_search(4'd0, 4'd3, 0);
    check("t1_done_cyc",  32'(done_cyc),  32'd9);
    check("t1_done_cnt",  32'(done_seen), 32'd1);
    check("t1_busy_c1",   32'(busy_c1),   32'd1);
    check("t1_busy_after",32'(busy_after),32'd0);
    check("t1_rd_count",  32'(rd_addr_q.size()), 32'd4);
    if (rd_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_rd_addr", 32'(rd_addr_q[i]), 32'(i));
        check("t1_rd_cyc",  32'(rd_cyc_q[i]),  32'(2 * i + 1));
      end
    end
    check("t1_max_val",   32'(max_val),   32'd9);
    check("t1_max_addr",  32'(max_addr),  32'd1);
    check("t1_err",       32'(err),       32'd0);

    // Ties keep the lowest address
    run_search(4'd4, 4'd7, 0);
    check("t2_done_cyc",  32'(done_cyc),  32'd9);
    check("t2_max_val",   32'(max_val),   32'd8);
    check("t2_max_addr",  32'(max_addr),  32'd5);
    check("t2_err",       32'(err),       32'd0);

    // Single word at the top of the address range
    run_search(4'd15, 4'd15, 0);
    check("t3_done_cyc",  32'(done_cyc),  32'd3);
    check("t3_done_cnt",  32'(done_seen), 32'd1);
    check("t3_rd_count",  32'(rd_addr_q.size()), 32'd1);
    check("t3_max_val",   32'(max_val),   32'd0);
    check("t3_max_addr",  32'(max_addr),  32'd15);
    check("t3_mem_addr",  32'(mem_addr),  32'd15);

    // Invalid window
    run_search(4'd6, 4'd2, 0);
    check("t4_done_cyc",  32'(done_cyc),  32'd1);
    check("t4_err",       32'(err),       32'd1);
    check("t4_rd_count",  32'(rd_addr_q.size()), 32'd0);
    check("t4_max_val",   32'(max_val),   32'd0);
    check("t4_max_addr",  32'(max_addr),  32'd6);

    // Start while busy is ignored
    run_search(4'd0, 4'd3, 4);
    check("t5_done_cyc",  32'(done_cyc),  32'd9);
    check("t5_done_cnt",  32'(done_seen), 32'd1);
    check("t5_rd_count",  32'(rd_addr_q.size()), 32'd4);
    check("t5_max_val",   32'(max_val),   32'd9);
    check("t5_max_addr",  32'(max_addr),  32'd1);
    check("t5_err",       32'(err),       32'd0);

    // Reset during the second COMPARE of window 4..7
    @(negedge clk);
    first_addr = 4'd4;
    last_addr  = 4'd7;
    start      = 1'b1;
    @(negedge clk);            // cycle 1
    start = 1'b0;
    @(negedge clk);            // cycle 2
    @(negedge clk);            // cycle 3
    @(negedge clk);            // cycle 4, COMPARE of addr 5
    check("t6_pre_max_val",  32'(max_val),  32'd5);
    check("t6_pre_mem_addr", 32'(mem_addr), 32'd5);
    reset_n = 1'b0;
    #1;
    check("t6_busy",     32'(busy),     32'd0);
    check("t6_done",     32'(done),     32'd0);
    check("t6_err",      32'(err),      32'd0);
    check("t6_mem_rd",   32'(mem_rd),   32'd0);
    check("t6_mem_addr", 32'(mem_addr), 32'd0);
    check("t6_max_val",  32'(max_val),  32'd0);
    check("t6_max_addr", 32'(max_addr), 32'd0);
    reset_dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) reset_dones++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) reset_dones++;
    end
    check("t6_no_done",  32'(reset_dones), 32'd0);
    $display("reset mid-search dones_after_reset=%0d", reset_dones);

    // Clean search after reset
    run_search(4'd8, 4'd11, 0);
    check("t7_done_cyc",  32'(done_cyc),  32'd9);
    check("t7_done_cnt",  32'(done_seen), 32'd1);
    check("t7_max_val",   32'(max_val),   32'd201);
    check("t7_max_addr",  32'(max_addr),  32'd10);
    check("t7_err",       32'(err),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/range_max_finder.md
# range_max_finder

Sequenced max-search engine: on `start`, walks a synchronous-read memory from `first_addr` to `last_addr` inclusive and reports the largest unsigned word and its address. It pairs its own controller FSM with a compare/register datapath. A start/busy/done handshake lets a higher-level controller invoke it repeatedly over different address windows.

## Interface
- `DATA_W`, 8, memory word width; values compared unsigned
- `ADDR_W`, 4, memory address width
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a search; sampled only in IDLE
- `first_addr`  in  ADDR_W  first address of window; latched on accepted start
- `last_addr`  in  ADDR_W  last address of window (inclusive); latched on accepted start
- `mem_rd`  out  1  memory read strobe
- `mem_addr`  out  ADDR_W  memory read address
- `mem_din`  in  DATA_W  read data, valid the cycle after `mem_rd`
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse; results valid
- `err`  out  1  window invalid (`first_addr > last_addr`); valid with `done`
- `max_val`  out  DATA_W  maximum word found
- `max_addr`  out  ADDR_W  address of maximum

## Operation
- States: IDLE, ISSUE, COMPARE, DONE.
- IDLE:
  - `start=1` → latch window, `addr <= first_addr`, `max_val <= 0`, `max_addr <= first_addr`, `err <= 0`, `first <= 1`.
  - Go to ISSUE if `first_addr <= last_addr`.
  - Otherwise set `err <= 1` and go to DONE.
- ISSUE: `mem_rd=1`, `mem_addr=addr`; go to COMPARE.
- COMPARE (`mem_din` valid):
  - Update condition: `first==1` or `mem_din > max_val` (strict). On update, `max_val <= mem_din`, `max_addr <= addr`. Clear `first`.
  - If `addr == last_addr` → DONE; else `addr <= addr+1` → ISSUE.
  - Compare happens before increment, so `last_addr = 2^ADDR_W-1` terminates without wrap.
- DONE: `done=1` for exactly one cycle; go to IDLE.
- Ties keep the lowest address (strict `>`).
- `max_val`, `max_addr` and `err` hold after DONE until the next accepted `start`.
- `start` outside IDLE is ignored; window inputs may change freely while busy.
- `mem_rd` is high only in ISSUE. `mem_addr` holds `addr` in all states (don't-care when `mem_rd=0`).
- Reset (async assert, any state): state IDLE, `busy=0`, `done=0`, `err=0`, `mem_rd=0`, `mem_addr=0`, `max_val=0`, `max_addr=0`. An in-flight search is abandoned and no `done` is produced.

## Timing
- Start accepted at edge 0 (IDLE). ISSUE occupies cycle 1, COMPARE cycle 2, and so on.
- For an N-word window (N = last−first+1): ISSUE/COMPARE alternate for 2N cycles, and `done` is high in cycle 2N+1.
- Total latency from start edge to `done`: 2N+1 cycles.
- Invalid window: `done` and `err` are high in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive. It is low the cycle after `done`, and a new `start` is accepted on that cycle.
- Outputs are registered. `mem_din` is consumed combinationally only in COMPARE.

## Test plan
- Memory {3,9,2,7} at 0..3, window 0..3, start → `mem_rd` pulses at addr 0,1,2,3 on alternate cycles; `done` at cycle 9; `max_val=9`, `max_addr=1`, `err=0`.
- Ties: {5,8,8,1} at 4..7, window 4..7 → `max_val=8`, `max_addr=5`.
- Single word and top-of-range: window 15..15, mem[15]=0 → `max_val=0`, `max_addr=15`, `done` at cycle 3, no address wrap.
- Invalid window: first=6, last=2 → `done` and `err` at cycle 1, `max_val=0`, `max_addr=6`, `mem_rd` never asserted.
- Start while busy: pulse `start` with a new window mid-search → ignored; the original result is reported and `done` occurs exactly once.
- Reset mid-search: assert `reset_n=0` during COMPARE → all outputs immediately take reset values and `done` never fires. A subsequent start runs a clean search and returns correct results.
